// File: rtl/deg2phase_stream_if.sv
// Stream bundle for deg2phase_stream: angle/tag request side and phase/tag/wrap result side.
interface deg2phase_stream_if #(
  parameter int DW    = 16,
  parameter int DEG_W = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [DEG_W-1:0] deg_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    phase_o;
  logic [TAG_W-1:0] tag_o;
  logic             wrap_o;

  modport master (
    output in_valid, deg_in, tag_in, out_ready,
    input  in_ready, out_valid, phase_o, tag_o, wrap_o
  );

  modport slave (
    input  in_valid, deg_in, tag_in, out_ready,
    output in_ready, out_valid, phase_o, tag_o, wrap_o
  );
endinterface

// File: rtl/deg2phase_stream.sv
// Streaming degrees -> CORDIC phase code converter, 3-stage pipeline with
// valid/ready backpressure, tag passthrough, round-half-up and wrap flag.
module deg2phase_stream #(
  parameter int DW        = 16,
  parameter int DEG_W     = 16,
  parameter int DEG_FRAC  = 7,
  parameter int KF        = 16,
  parameter int TAG_W     = 4,
  parameter int SIGNED_IN = 0
) (
  input logic              clk,
  input logic              rst_n,
  deg2phase_stream_if.slave bus
);

  localparam int KW = DW + KF - 6;
  localparam int PW = DEG_W + KW;
  localparam int SH = KF + DEG_FRAC;
  localparam longint unsigned K_VAL = ((64'd1 << (DW - 1 + KF)) + 64'd90) / 64'd180;
  localparam logic signed [KW-1:0] K = K_VAL[KW-1:0];
  localparam logic signed [PW-1:0] RND = {{(PW-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};

  logic             v1, v2, v3;
  logic [DEG_W-1:0] deg1;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic signed [PW-1:0] prod2;
  logic [DW-1:0]    phase3;
  logic             wrap3;

  logic                 adv;
  logic                 ext_bit;
  logic signed [PW-1:0] deg_ext;
  logic signed [PW-1:0] k_ext;
  logic signed [PW-1:0] prod_next;
  logic signed [PW-1:0] sum;
  logic signed [PW-1:0] shifted;

  assign adv          = bus.out_ready | ~v3;
  assign bus.in_ready = adv & rst_n;

  always_comb begin
    ext_bit   = (SIGNED_IN != 0) && deg1[DEG_W-1];
    deg_ext   = {{(PW-DEG_W){ext_bit}}, deg1};
    k_ext     = {{(PW-KW){K[KW-1]}}, K};
    prod_next = deg_ext * k_ext;
    sum       = prod2 + RND;
    shifted   = sum >>> SH;
  end

  // The whole pipe moves as one: a stall freezes every stage, bubbles included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      deg1   <= '0;
      tag1   <= '0;
      tag2   <= '0;
      tag3   <= '0;
      prod2  <= '0;
      phase3 <= '0;
      wrap3  <= 1'b0;
    end else if (adv) begin
      v1     <= bus.in_valid;
      deg1   <= bus.deg_in;
      tag1   <= bus.tag_in;
      v2     <= v1;
      prod2  <= prod_next;
      tag2   <= tag1;
      v3     <= v2;
      phase3 <= shifted[DW-1:0];
      wrap3  <= |shifted[PW-1:DW];
      tag3   <= tag2;
    end
  end

  assign bus.out_valid = v3;
  assign bus.phase_o   = phase3;
  assign bus.tag_o     = tag3;
  assign bus.wrap_o    = wrap3;

endmodule

// File: tb/tb_deg2phase_stream.sv
// Directed and scoreboard checks for deg2phase_stream in unsigned and signed modes.
module tb_deg2phase_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  deg2phase_stream_if #(.DW(16), .DEG_W(16), .TAG_W(4)) bus_u ();
  deg2phase_stream_if #(.DW(16), .DEG_W(16), .TAG_W(4)) bus_s ();

  deg2phase_stream #(.DW(16), .DEG_W(16), .DEG_FRAC(7), .KF(16), .TAG_W(4), .SIGNED_IN(0))
    dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));

  deg2phase_stream #(.DW(16), .DEG_W(16), .DEG_FRAC(7), .KF(16), .TAG_W(4), .SIGNED_IN(1))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  // Exact rational reference: deg/128 * 2^15/180 = d*64/45, rounded half-up, {wrap, phase}.
  function automatic logic [16:0] ref_phase(input logic [15:0] d, input bit sgn);
    longint v, n, q;
    v = sgn ? longint'($signed(d)) : longint'({48'd0, d});
    n = v * 128 + 45;
    q = n / 90;
    if ((n % 90 != 0) && (n < 0)) q = q - 1;
    ref_phase = {(q < 0 || q >= 65536), q[15:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus_u.in_valid = 1'b1; bus_u.deg_in = 16'd11520; bus_u.tag_in = 4'd5; bus_u.out_ready = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.deg_in = '0; bus_s.tag_in = '0; bus_s.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus_u.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", bus_u.in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o} !== 22'd0)
      $display("FAIL reset_outputs: got v=%b p=%h t=%h w=%b expected all 0",
               bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o);
    else pass_cnt++;
    bus_u.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    bus_u.in_valid = 1'b1; bus_u.deg_in = 16'd11520; bus_u.tag_in = 4'd3; bus_u.out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus_u.in_ready !== 1'b1) $display("FAIL lat_in_ready: got %b expected 1", bus_u.in_ready);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus_u.in_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (c < 2) begin
        if (bus_u.out_valid !== 1'b0) $display("FAIL lat_early_%0d: out_valid got %b expected 0", c, bus_u.out_valid);
        else pass_cnt++;
      end else begin
        if ({bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o} !== {1'b1, 16'h4000, 4'd3, 1'b0})
          $display("FAIL lat_90deg: got v=%b p=%h t=%h w=%b expected v=1 p=4000 t=3 w=0",
                   bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o);
        else pass_cnt++;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] din [4] = '{16'd128, 16'd23040, 16'd34560, 16'd46080};
    logic [15:0] exp_p [4] = '{16'h00B6, 16'h8000, 16'hC000, 16'h0000};
    logic        exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    #1;
    bus_u.in_valid = 1'b1; bus_u.deg_in = din[0]; bus_u.tag_in = 4'd0; bus_u.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c + 1 < 4) begin
        bus_u.deg_in = din[c+1]; bus_u.tag_in = 4'(c + 1);
      end else bus_u.in_valid = 1'b0;
      @(negedge clk);
      if (c >= 2) begin
        total_cnt++;
        if ({bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o} !==
            {1'b1, exp_p[c-2], 4'(c - 2), exp_w[c-2]})
          $display("FAIL key_angle_%0d: got v=%b p=%h t=%h w=%b expected v=1 p=%h t=%0d w=%b",
                   c - 2, bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o,
                   exp_p[c-2], c - 2, exp_w[c-2]);
        else pass_cnt++;
      end
    end
    @(negedge clk);
    total_cnt++;
    if (bus_u.out_valid !== 1'b0) $display("FAIL key_angle_tail: out_valid got %b expected 0", bus_u.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    logic [15:0] din [3] = '{16'hD300, 16'hA600, 16'd11520};
    logic [15:0] exp_p [3] = '{16'hC000, 16'h8000, 16'h4000};
    logic        exp_w [3] = '{1'b1, 1'b1, 1'b0};
    @(posedge clk); #1;
    bus_s.in_valid = 1'b1; bus_s.deg_in = din[0]; bus_s.tag_in = 4'd10; bus_s.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c + 1 < 3) begin
        bus_s.deg_in = din[c+1]; bus_s.tag_in = 4'(11 + c);
      end else bus_s.in_valid = 1'b0;
      @(negedge clk);
      if (c >= 2) begin
        total_cnt++;
        if ({bus_s.out_valid, bus_s.phase_o, bus_s.tag_o, bus_s.wrap_o} !==
            {1'b1, exp_p[c-2], 4'(8 + c), exp_w[c-2]})
          $display("FAIL signed_%0d: got v=%b p=%h t=%h w=%b expected v=1 p=%h t=%0d w=%b",
                   c - 2, bus_s.out_valid, bus_s.phase_o, bus_s.tag_o, bus_s.wrap_o,
                   exp_p[c-2], 8 + c, exp_w[c-2]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    bus_u.in_valid = 1'b1; bus_u.deg_in = 16'd128; bus_u.tag_in = 4'd1; bus_u.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus_u.deg_in = 16'd256 + 16'(c); bus_u.tag_in = 4'(c + 2);
    end
    bus_u.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus_u.in_ready !== 1'b0) $display("FAIL mid_rst_in_ready: got %b expected 0", bus_u.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_u.out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus_u.out_valid !== 1'b0) $display("FAIL mid_rst_flush: out_valid got %b expected 0", bus_u.out_valid);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total_cnt++;
      if (bus_u.out_valid !== 1'b0) $display("FAIL mid_rst_ghost_%0d: out_valid got %b expected 0", c, bus_u.out_valid);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    bus_u.in_valid = 1'b1; bus_u.deg_in = 16'd5760; bus_u.tag_in = 4'd9;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus_u.in_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (c < 2) begin
        if (bus_u.out_valid !== 1'b0) $display("FAIL mid_rst_early_%0d: out_valid got %b expected 0", c, bus_u.out_valid);
        else pass_cnt++;
      end else begin
        if ({bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o} !== {1'b1, 16'h2000, 4'd9, 1'b0})
          $display("FAIL mid_rst_resume: got v=%b p=%h t=%h w=%b expected v=1 p=2000 t=9 w=0",
                   bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o);
        else pass_cnt++;
      end
    end
  endtask

  // Scoreboarded stream on the unsigned DUT; rnd selects random data/valid/ready, else table + pattern.
  task automatic run_stream(input int n, input bit rnd, input logic [63:0] pat, input string name);
    logic [15:0] bp_deg [8] = '{16'd0, 16'd128, 16'd11520, 16'd23040, 16'd34560, 16'd46080, 16'd65535, 16'd5760};
    logic [15:0] qd [$];
    logic [3:0]  qt [$];
    logic [15:0] ed, sp;
    logic [3:0]  et, st;
    logic [16:0] ex;
    logic        sw;
    bit          stalled, accepted;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stalled = 0;
    @(posedge clk); #1;
    bus_u.in_valid = 1'b1;
    bus_u.deg_in = rnd ? 16'($urandom) : bp_deg[0];
    bus_u.tag_in = 4'd0;
    bus_u.out_ready = rnd ? ($urandom_range(0, 3) != 0) : pat[0];
    while (got < n && cyc < n * 8 + 200) begin
      @(negedge clk);
      if (stalled) begin
        total_cnt++;
        if ({bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o} !== {1'b1, sp, st, sw})
          $display("FAIL %s_stall_hold: got v=%b p=%h t=%h w=%b expected v=1 p=%h t=%h w=%b", name,
                   bus_u.out_valid, bus_u.phase_o, bus_u.tag_o, bus_u.wrap_o, sp, st, sw);
        else pass_cnt++;
      end
      total_cnt++;
      if (bus_u.in_ready !== !(bus_u.out_valid && !bus_u.out_ready))
        $display("FAIL %s_in_ready: got %b expected %b", name, bus_u.in_ready,
                 !(bus_u.out_valid && !bus_u.out_ready));
      else pass_cnt++;
      if (bus_u.out_valid && bus_u.out_ready) begin
        if (qd.size() == 0) begin
          total_cnt++;
          $display("FAIL %s_extra_output: got p=%h with 0 expected pending", name, bus_u.phase_o);
        end else begin
          ed = qd.pop_front();
          et = qt.pop_front();
          ex = ref_phase(ed, 1'b0);
          total_cnt++;
          if ({bus_u.phase_o, bus_u.wrap_o} !== {ex[15:0], ex[16]})
            $display("FAIL %s_phase: deg_in=%h got p=%h w=%b expected p=%h w=%b", name, ed,
                     bus_u.phase_o, bus_u.wrap_o, ex[15:0], ex[16]);
          else pass_cnt++;
          total_cnt++;
          if (bus_u.tag_o !== et) $display("FAIL %s_tag: got %h expected %h", name, bus_u.tag_o, et);
          else pass_cnt++;
        end
        got++;
      end
      stalled = bus_u.out_valid && !bus_u.out_ready;
      sp = bus_u.phase_o; st = bus_u.tag_o; sw = bus_u.wrap_o;
      accepted = bus_u.in_valid && bus_u.in_ready;
      if (accepted) begin
        qd.push_back(bus_u.deg_in);
        qt.push_back(bus_u.tag_in);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted || !bus_u.in_valid) begin
        if (sent < n && (!rnd || $urandom_range(0, 4) != 0)) begin
          bus_u.in_valid = 1'b1;
          bus_u.deg_in = rnd ? 16'($urandom) : bp_deg[sent];
          bus_u.tag_in = sent[3:0];
        end else bus_u.in_valid = 1'b0;
      end
      bus_u.out_ready = rnd ? ($urandom_range(0, 3) != 0) : pat[cyc[5:0]];
    end
    bus_u.in_valid = 1'b0;
    bus_u.out_ready = 1'b1;
    total_cnt++;
    if (got !== n) $display("FAIL %s_count: got %0d results expected %0d within cycle budget", name, got, n);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (bus_u.out_valid !== 1'b0) $display("FAIL %s_drain: out_valid got %b expected 0", name, bus_u.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    // Cycles 9..13 hold out_ready low for five consecutive cycles.
    run_stream(8, 1'b0, 64'hFFFF_FFFF_FFFF_C1AD, "backpressure");
  endtask

  task automatic test_random();
    run_stream(10000, 1'b1, 64'h0, "random");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_signed();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
